sisc_pcu: RTL and testbench

SISC_PCU -- requirements
Module: sisc_pcu

---
 rtl/sisc_pkg.sv | 17 +
 rtl/sisc_ras.sv | 67 ++++++
 rtl/sisc_pcu.sv | 120 ++++++++++++
 tb/tb_sisc_pcu.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC program-control unit: pc_op encodings
// and the default reset vector.
package sisc_pkg;

   // Program-counter operation codes; 5..7 are reserved and behave as SEQ.
   typedef enum logic [2:0] {
      OP_SEQ    = 3'd0,
      OP_BR_REL = 3'd1,
      OP_BR_ABS = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4
   } pc_op_e;

   // Default PC value loaded on reset.
   localparam int unsigned RESET_VEC_DEFAULT = 0;

endpackage : sisc_pkg

// File: rtl/sisc_ras.sv
// Return-address stack: LIFO of ADDR_W-bit entries with occupancy count.
// The top entry is read combinationally so the PC mux can use it in the
// same cycle a RET is decoded. Push on full and pop on empty are ignored.
module sisc_ras #(
   parameter int ADDR_W    = 16,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [ADDR_W-1:0]            push_data,
   output logic [ADDR_W-1:0]            top,
   output logic [$clog2(RAS_DEPTH):0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int IDX_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == CNT_W'(RAS_DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   // The next free slot is the count itself; the top sits just below it.
   assign wr_idx  = count_q[IDX_W-1:0];
   assign top_idx = wr_idx - IDX_W'(1);
   assign top     = mem_q[top_idx];
   assign count   = count_q;

   // Occupancy update; push and pop are never requested together.
   always_comb begin
      count_d = count_q;
      if (push_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Occupancy register; reset empties the stack without touching storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage; contents are never cleared, empty count hides them.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         mem_q[wr_idx] <= push_data;
      end
   end

endmodule : sisc_ras

// File: rtl/sisc_pcu.sv
// SISC program-control unit: registered PC with sequential, relative and
// absolute branches, CALL/RET through a return-address stack, and sticky
// overflow/underflow flags. pc_next is selected combinationally.
module sisc_pcu
   import sisc_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pc_write,
   input  logic [2:0]                   pc_op,
   input  logic                         cond_ok,
   input  logic [ADDR_W-1:0]            imm,
   input  logic                         err_clr,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W-1:0]            pc_next,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ovf_err,
   output logic                         unf_err
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] ras_top;
   logic              ovf_q;
   logic              unf_q;
   logic              push_req;
   logic              pop_req;
   logic              ovf_set;
   logic              unf_set;

   assign pc_plus1 = pc_q + ADDR_W'(1);

   // Next-PC selection and stack/flag requests; untaken ops fall through to pc+1.
   always_comb begin
      pc_d     = pc_plus1;
      push_req = 1'b0;
      pop_req  = 1'b0;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      if (cond_ok) begin
         case (pc_op)
            OP_BR_REL: pc_d = pc_plus1 + imm;
            OP_BR_ABS: pc_d = imm;
            OP_CALL: begin
               if (!ras_full) begin
                  push_req = 1'b1;
                  pc_d     = imm;
               end else begin
                  ovf_set  = 1'b1;
               end
            end
            OP_RET: begin
               if (!ras_empty) begin
                  pop_req = 1'b1;
                  pc_d    = ras_top;
               end else begin
                  unf_set = 1'b1;
               end
            end
            default: pc_d = pc_plus1;
         endcase
      end
   end

   // Program counter register, advanced only when pc_write is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_VEC;
      end else if (pc_write) begin
         pc_q <= pc_d;
      end
   end

   // Sticky error flags: a qualifying set wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (pc_write && ovf_set) begin
            ovf_q <= 1'b1;
         end else if (err_clr) begin
            ovf_q <= 1'b0;
         end
         if (pc_write && unf_set) begin
            unf_q <= 1'b1;
         end else if (err_clr) begin
            unf_q <= 1'b0;
         end
      end
   end

   sisc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req & pc_write),
      .pop       (pop_req & pc_write),
      .push_data (pc_plus1),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign pc      = pc_q;
   assign pc_next = pc_d;
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;

endmodule : sisc_pcu

// File: tb/tb_sisc_pcu.sv
// Directed self-checking bench for sisc_pcu (ADDR_W=16, RAS_DEPTH=8).
module tb_sisc_pcu;

   localparam logic [2:0] SEQ = 3'd0, BRR = 3'd1, BRA = 3'd2, CALL = 3'd3, RET = 3'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b0;
   logic [2:0]  pc_op = 3'd0;
   logic        cond_ok = 1'b0;
   logic [15:0] imm = 16'h0;
   logic        err_clr = 1'b0;
   logic [15:0] pc;
   logic [15:0] pc_next;
   logic [3:0]  ras_count;
   logic        ras_full;
   logic        ras_empty;
   logic        ovf_err;
   logic        unf_err;

   int vectors = 0;
   int miscompares = 0;

   sisc_pcu #(.ADDR_W(16), .RAS_DEPTH(8), .RESET_VEC(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_write  (pc_write),
      .pc_op     (pc_op),
      .cond_ok   (cond_ok),
      .imm       (imm),
      .err_clr   (err_clr),
      .pc        (pc),
      .pc_next   (pc_next),
      .ras_count (ras_count),
      .ras_full  (ras_full),
      .ras_empty (ras_empty),
      .ovf_err   (ovf_err),
      .unf_err   (unf_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout pc=%h", pc);
      $fatal(1, "watchdog");
   end

   // One clock with the given inputs; outputs sampled 1ns after the edge.
   task automatic step(input logic wr, input logic [2:0] op, input logic c,
                       input logic [15:0] im, input logic clr);
      pc_write = wr; pc_op = op; cond_ok = c; imm = im; err_clr = clr;
      @(posedge clk);
      #1;
      $display("txn rst=%0b wr=%0b op=%0d cond=%0b imm=%h clr=%0b -> pc=%h cnt=%0d ovf=%0b unf=%0b",
               rst, wr, op, c, im, clr, pc, ras_count, ovf_err, unf_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, CALL, 1'b1, 16'h5555, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (pc !== 16'h0000 || ras_count !== 4'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
          ovf_err !== 1'b0 || unf_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset pc=%h cnt=%0d empty=%0b full=%0b ovf=%0b unf=%0b required 0000/0/1/0/0/0",
                  pc, ras_count, ras_empty, ras_full, ovf_err, unf_err);
      end
   endtask

   task automatic test_seq();
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, SEQ, 1'b0, 16'h0, 1'b0);
         vectors++;
         if (pc !== 16'(i) || ras_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL seq%0d pc=%h empty=%0b required %h/1", i, pc, ras_empty, 16'(i));
         end
      end
      // Combinational pc_next: pc=3, BR_REL +5 taken -> 3+1+5 = 9, no edge.
      pc_write = 1'b0; pc_op = BRR; cond_ok = 1'b1; imm = 16'h0005;
      #1;
      vectors++;
      if (pc_next !== 16'h0009) begin
         miscompares++;
         $display("FAIL pc_next_comb got %h required 0009", pc_next);
      end
      // pc_write=0 holds pc.
      step(1'b0, BRR, 1'b1, 16'h0005, 1'b0);
      vectors++;
      if (pc !== 16'h0003) begin
         miscompares++;
         $display("FAIL hold pc=%h required 0003", pc);
      end
   endtask

   task automatic test_br_rel();
      step(1'b1, BRA, 1'b1, 16'h0010, 1'b0);
      step(1'b1, BRR, 1'b1, 16'hFFFE, 1'b0);
      vectors++;
      if (pc !== 16'h000F) begin
         miscompares++;
         $display("FAIL br_rel_taken pc=%h required 000f", pc);
      end
      step(1'b1, BRA, 1'b1, 16'h0010, 1'b0);
      step(1'b1, BRR, 1'b0, 16'hFFFE, 1'b0);
      vectors++;
      if (pc !== 16'h0011) begin
         miscompares++;
         $display("FAIL br_rel_not_taken pc=%h required 0011", pc);
      end
   endtask

   task automatic test_wrap_abs();
      step(1'b1, BRA, 1'b1, 16'hFFFF, 1'b0);
      step(1'b1, SEQ, 1'b1, 16'h7777, 1'b0);
      vectors++;
      if (pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL seq_wrap pc=%h required 0000", pc);
      end
      step(1'b1, BRA, 1'b1, 16'h1234, 1'b0);
      vectors++;
      if (pc !== 16'h1234) begin
         miscompares++;
         $display("FAIL br_abs pc=%h required 1234", pc);
      end
      step(1'b1, BRA, 1'b0, 16'h4000, 1'b0);
      vectors++;
      if (pc !== 16'h1235) begin
         miscompares++;
         $display("FAIL br_abs_not_taken pc=%h required 1235", pc);
      end
      // Reserved op 5 with cond_ok=1: plain increment, no stack change.
      step(1'b1, 3'd5, 1'b1, 16'h4000, 1'b0);
      vectors++;
      if (pc !== 16'h1236 || ras_count !== 4'd0 || ovf_err !== 1'b0 || unf_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reserved_op pc=%h cnt=%0d required 1236/0", pc, ras_count);
      end
   endtask

   task automatic test_call_ret();
      logic [15:0] exp_pc [4];
      logic [3:0]  exp_cnt [4];
      exp_pc[0] = 16'h0100; exp_pc[1] = 16'h0200; exp_pc[2] = 16'h0106; exp_pc[3] = 16'h0021;
      exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd1; exp_cnt[3] = 4'd0;
      step(1'b1, BRA, 1'b1, 16'h0020, 1'b0);
      step(1'b1, CALL, 1'b0, 16'h0900, 1'b0);
      vectors++;
      if (pc !== 16'h0021 || ras_count !== 4'd0) begin
         miscompares++;
         $display("FAIL call_not_taken pc=%h cnt=%0d required 0021/0", pc, ras_count);
      end
      step(1'b1, BRA, 1'b1, 16'h0020, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) step(1'b1, BRA, 1'b1, 16'h0105, 1'b0);
         case (i)
            0: step(1'b1, CALL, 1'b1, 16'h0100, 1'b0);
            1: step(1'b1, CALL, 1'b1, 16'h0200, 1'b0);
            default: step(1'b1, RET, 1'b1, 16'h0000, 1'b0);
         endcase
         vectors++;
         if (pc !== exp_pc[i] || ras_count !== exp_cnt[i]) begin
            miscompares++;
            $display("FAIL call_ret%0d pc=%h cnt=%0d required %h/%0d", i, pc, ras_count, exp_pc[i], exp_cnt[i]);
         end
      end
   endtask

   task automatic test_overflow_underflow();
      logic [15:0] tgt;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tgt = 16'h1000 + 16'(i * 16);
         step(1'b1, CALL, 1'b1, tgt, 1'b0);
         vectors++;
         if (pc !== tgt || ras_count !== 4'(i + 1) || ras_full !== (i == 7)) begin
            miscompares++;
            $display("FAIL call_fill%0d pc=%h cnt=%0d full=%0b required %h/%0d/%0b",
                     i, pc, ras_count, ras_full, tgt, i + 1, (i == 7));
         end
      end
      step(1'b1, CALL, 1'b1, 16'h2000, 1'b0);
      vectors++;
      if (pc !== 16'h1071 || ras_count !== 4'd8 || ovf_err !== 1'b1) begin
         miscompares++;
         $display("FAIL call_overflow pc=%h cnt=%0d ovf=%0b required 1071/8/1", pc, ras_count, ovf_err);
      end
      // Unwind: pushes were 0001, 1001, 1011, ... 1061 (caller pc + 1).
      for (int i = 7; i >= 0; i--) begin
         tgt = (i == 0) ? 16'h0001 : (16'h1000 + 16'((i - 1) * 16) + 16'h0001);
         step(1'b1, RET, 1'b1, 16'h0000, 1'b0);
         vectors++;
         if (pc !== tgt || ras_count !== 4'(i)) begin
            miscompares++;
            $display("FAIL ret_unwind%0d pc=%h cnt=%0d required %h/%0d", i, pc, ras_count, tgt, i);
         end
      end
      step(1'b1, RET, 1'b1, 16'h0000, 1'b0);
      vectors++;
      if (pc !== 16'h0002 || unf_err !== 1'b1 || ovf_err !== 1'b1 || ras_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL ret_underflow pc=%h unf=%0b ovf=%0b required 0002/1/1", pc, unf_err, ovf_err);
      end
      step(1'b0, SEQ, 1'b0, 16'h0000, 1'b1);
      vectors++;
      if (ovf_err !== 1'b0 || unf_err !== 1'b0 || pc !== 16'h0002) begin
         miscompares++;
         $display("FAIL err_clr ovf=%0b unf=%0b pc=%h required 0/0/0002", ovf_err, unf_err, pc);
      end
      // Underflow set and clear in the same cycle: set wins.
      step(1'b1, RET, 1'b1, 16'h0000, 1'b1);
      vectors++;
      if (unf_err !== 1'b1 || ovf_err !== 1'b0 || pc !== 16'h0003) begin
         miscompares++;
         $display("FAIL set_over_clr unf=%0b ovf=%0b pc=%h required 1/0/0003", unf_err, ovf_err, pc);
      end
      // Underflow condition with pc_write=0 must not set anything.
      step(1'b0, SEQ, 1'b0, 16'h0000, 1'b1);
      step(1'b0, RET, 1'b1, 16'h0000, 1'b0);
      vectors++;
      if (unf_err !== 1'b0 || pc !== 16'h0003) begin
         miscompares++;
         $display("FAIL no_set_without_write unf=%0b pc=%h required 0/0003", unf_err, pc);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, CALL, 1'b1, 16'h0300, 1'b0);
      step(1'b1, CALL, 1'b1, 16'h0400, 1'b0);
      step(1'b1, CALL, 1'b1, 16'h0500, 1'b0);
      vectors++;
      if (ras_count !== 4'd3 || pc !== 16'h0500) begin
         miscompares++;
         $display("FAIL pre_reset_push cnt=%0d pc=%h required 3/0500", ras_count, pc);
      end
      rst = 1'b1;
      step(1'b1, BRA, 1'b1, 16'h0777, 1'b1);
      rst = 1'b0;
      vectors++;
      if (pc !== 16'h0000 || ras_count !== 4'd0 || ras_empty !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset pc=%h cnt=%0d empty=%0b required 0000/0/1", pc, ras_count, ras_empty);
      end
      step(1'b1, RET, 1'b1, 16'h0000, 1'b0);
      vectors++;
      if (unf_err !== 1'b1 || pc !== 16'h0001 || ras_count !== 4'd0) begin
         miscompares++;
         $display("FAIL ret_after_reset unf=%0b pc=%h cnt=%0d required 1/0001/0", unf_err, pc, ras_count);
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_br_rel();
      test_wrap_abs();
      test_call_ret();
      test_overflow_underflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sisc_pcu
